// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between num_req requesters.
// Times each frame with a local counter because the sender has no busy output.
module uart_tx_arbiter #(
    parameter int num_req    = 4,
    parameter int bit_cycles = 4,
    parameter int frame_bits = 10,
    parameter int gap_cycles = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [num_req-1:0]   req,
    input  logic [7*num_req-1:0] data_in,
    output logic [num_req-1:0]   ack,
    output logic                 tx_flag,
    output logic [6:0]           tx_data,
    output logic                 busy,
    output logic [15:0]          sent_cnt,
    output logic [1:0]           state
);

    localparam int frame_cycles = bit_cycles * frame_bits;
    localparam int max_cycles   = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
    localparam int cnt_w        = $clog2(max_cycles) + 1;
    localparam int idx_w        = (num_req > 1) ? $clog2(num_req) : 1;

    localparam logic [cnt_w-1:0] send_last = cnt_w'(frame_cycles - 1);
    localparam logic [cnt_w-1:0] gap_last  = cnt_w'(gap_cycles - 1);
    localparam logic [idx_w-1:0] last_init = idx_w'(num_req - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Handshake: req is a level held until the one-cycle ack pulse. ack means
    // the requester's data_in slice was captured in that same clock edge, so
    // the requester may change data_in/req from the cycle after ack onwards.

    state_t           cur;
    logic [cnt_w-1:0] cnt;
    logic [idx_w-1:0] last;
    logic             grant_valid;
    logic [idx_w-1:0] grant_idx;
    int               pos;
    logic [idx_w-1:0] sel;

    assign state = cur;

    // Scan starts just after the previous winner so every requester is reached
    // within num_req grants; the previous winner itself is checked last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last;
        pos         = 0;
        sel         = '0;
        for (int k = 1; k <= num_req; k++) begin
            pos = (int'(last) + k) % num_req;
            sel = pos[idx_w-1:0];
            if (!grant_valid && req[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            ack      <= '0;
            tx_flag  <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            sent_cnt <= '0;
            cnt      <= '0;
            last     <= last_init;
        end else begin
            ack <= '0;
            case (cur)
                IDLE: begin
                    if (grant_valid) begin
                        last           <= grant_idx;
                        tx_data        <= data_in[7*grant_idx +: 7];
                        ack[grant_idx] <= 1'b1;
                        tx_flag        <= 1'b1;
                        busy           <= 1'b1;
                        cnt            <= '0;
                        cur            <= SEND;
                    end
                end
                SEND: begin
                    // req is ignored here; waiting requesters are rescanned in IDLE.
                    if (cnt == send_last) begin
                        tx_flag <= 1'b0;
                        cnt     <= '0;
                        cur     <= GAP;
                    end else begin
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                GAP: begin
                    if (cnt == gap_last) begin
                        sent_cnt <= sent_cnt + 16'd1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        cur      <= IDLE;
                    end else begin
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                default: begin
                    cur     <= IDLE;
                    tx_flag <= 1'b0;
                    busy    <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    a_ack_onehot : assert property (@(posedge clk) $onehot0(ack));
    a_ack_at_grant : assert property (@(posedge clk) (ack != '0) |-> (cur == SEND && cnt == '0));
    a_busy_def : assert property (@(posedge clk) busy == (tx_flag || cur == GAP));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with default parameters (F=40, gap=2).
// Each task drives one scenario and checks its outputs inline.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int F   = 40;
    localparam int GAP = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [7*NR-1:0] data_in = '0;
    logic [NR-1:0] ack;
    logic          tx_flag;
    logic [6:0]    tx_data;
    logic          busy;
    logic [15:0]   sent_cnt;
    logic [1:0]    state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];

    uart_tx_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .tx_flag  (tx_flag),
        .tx_data  (tx_data),
        .busy     (busy),
        .sent_cnt (sent_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [6:0] d);
        data_in[7*i +: 7] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((state !== ST_IDLE || busy !== 1'b0) && k < 200) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL %s_idle: state=%0d busy=%b, required state=0 busy=0 within 200 cycles",
                     name, state, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        set_data(0, 7'h11);
        set_data(1, 7'h22);
        set_data(2, 7'h33);
        set_data(3, 7'h44);
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if ({ack, tx_flag, tx_data, busy, sent_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: ack=%b flag=%b data=%h busy=%b sent=%h, required all zero",
                         ack, tx_flag, tx_data, busy, sent_cnt);
            end
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (ack !== 4'b0001 || tx_data !== 7'h11 || tx_flag !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: ack=%b data=%h flag=%b busy=%b, required 0001/11/1/1",
                     ack, tx_data, tx_flag, busy);
        end
        req = '0;
        wait_idle("reset");
        n_cmp++;
        if (sent_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_sent: sent_cnt=%0d, required 1", sent_cnt);
        end
    endtask

    task automatic test_single();
        int hi;
        int lo;
        logic bad;
        set_data(2, 7'b1010101);
        req = 4'b0100;
        step();
        n_cmp++;
        if (ack !== 4'b0100 || tx_data !== 7'h55 || tx_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: ack=%b data=%h flag=%b, required 0100/55/1", ack, tx_data, tx_flag);
        end
        req = '0;
        hi  = 1;
        bad = 1'b0;
        while (tx_flag === 1'b1 && hi < 100) begin
            step();
            if (tx_flag === 1'b1) begin
                hi++;
                if (ack !== '0 || tx_data !== 7'h55 || busy !== 1'b1) bad = 1'b1;
            end
        end
        n_cmp++;
        if (hi !== F) begin
            n_fail++;
            $display("FAIL single_flag_len: tx_flag high %0d cycles, required %0d", hi, F);
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL single_frame_stable: ack/data/busy disturbed during frame, required stable");
        end
        lo = 0;
        while (busy === 1'b1 && tx_flag === 1'b0 && lo < 10) begin
            lo++;
            step();
        end
        n_cmp++;
        if (lo !== GAP) begin
            n_fail++;
            $display("FAIL single_gap_len: gap %0d cycles, required %0d", lo, GAP);
        end
        n_cmp++;
        if (sent_cnt !== 16'd2 || state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL single_sent: sent_cnt=%0d state=%0d, required 2/0", sent_cnt, state);
        end
    endtask

    task automatic test_withdrawal();
        int k;
        logic [NR-1:0] any_ack;
        set_data(0, 7'h0A);
        set_data(1, 7'h2B);
        set_data(3, 7'h3C);
        req = 4'b0001;
        step();
        n_cmp++;
        if (ack !== 4'b0001 || tx_data !== 7'h0A) begin
            n_fail++;
            $display("FAIL wd_first: ack=%b data=%h, required 0001/0a", ack, tx_data);
        end
        req = '0;
        for (int c = 0; c < 5; c++) step();
        req = 4'b1010;
        step();
        req = 4'b0010;
        k = 0;
        while (ack === '0 && k < 100) begin
            step();
            k++;
        end
        n_cmp++;
        if (ack !== 4'b0010 || tx_data !== 7'h2B || k !== 37) begin
            n_fail++;
            $display("FAIL wd_grant: ack=%b data=%h wait=%0d, required 0010/2b/37", ack, tx_data, k);
        end
        req = '0;
        wait_idle("withdrawal");
        any_ack = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            any_ack = any_ack | ack;
        end
        n_cmp++;
        if (any_ack !== '0) begin
            n_fail++;
            $display("FAIL wd_no_ack3: ack seen %b after withdrawal, required 0000", any_ack);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_data(2, 7'h55);
        req = 4'b0100;
        step();
        n_cmp++;
        if (ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_grant: ack=%b, required 0100", ack);
        end
        req = '0;
        for (int c = 0; c < 20; c++) step();
        n_cmp++;
        if (tx_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before: tx_flag=%b at cnt 20, required 1", tx_flag);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({ack, tx_flag, tx_data, busy, sent_cnt} !== '0 || state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL mid_abort: ack=%b flag=%b data=%h busy=%b sent=%h state=%0d, required all zero",
                     ack, tx_flag, tx_data, busy, sent_cnt, state);
        end
        rst = 1'b0;
        set_data(0, 7'h01);
        set_data(3, 7'h03);
        req = 4'b1001;
        step();
        n_cmp++;
        if (ack !== 4'b0001 || tx_data !== 7'h01) begin
            n_fail++;
            $display("FAIL mid_priority: ack=%b data=%h, required 0001/01", ack, tx_data);
        end
        req = '0;
        wait_idle("reset_mid");
        n_cmp++;
        if (sent_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_sent: sent_cnt=%0d, required 1", sent_cnt);
        end
    endtask

    task automatic test_round_robin();
        int got;
        int cyc;
        int last_cyc;
        logic [9:0] e;
        logic [NR-1:0] ea;
        apply_reset();
        set_data(0, 7'h11);
        set_data(1, 7'h22);
        set_data(2, 7'h33);
        set_data(3, 7'h44);
        exp_q.delete();
        exp_q.push_back({3'd0, 7'h11});
        exp_q.push_back({3'd1, 7'h22});
        exp_q.push_back({3'd2, 7'h33});
        exp_q.push_back({3'd3, 7'h44});
        exp_q.push_back({3'd0, 7'h11});
        req = 4'b1111;
        got = 0;
        cyc = 0;
        last_cyc = 0;
        while (got < 5 && cyc < 400) begin
            step();
            cyc++;
            if (ack !== '0) begin
                e  = exp_q.pop_front();
                ea = 4'b0001 << e[9:7];
                n_cmp++;
                if (ack !== ea || tx_data !== e[6:0]) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: ack=%b data=%h, required %b/%h", got, ack, tx_data, ea, e[6:0]);
                end
                if (got > 0) begin
                    n_cmp++;
                    if (cyc - last_cyc !== F + GAP + 1) begin
                        n_fail++;
                        $display("FAIL rr_spacing%0d: %0d cycles, required %0d", got, cyc - last_cyc, F + GAP + 1);
                    end
                end
                last_cyc = cyc;
                got++;
            end
        end
        n_cmp++;
        if (got !== 5) begin
            n_fail++;
            $display("FAIL rr_count: %0d grants, required 5", got);
        end
        req = '0;
        wait_idle("round_robin");
    endtask

    task automatic test_wrap();
        force dut.sent_cnt = 16'hFFFF;
        step();
        release dut.sent_cnt;
        set_data(0, 7'h7F);
        req = 4'b0001;
        step();
        n_cmp++;
        if (ack !== 4'b0001 || tx_data !== 7'h7F) begin
            n_fail++;
            $display("FAIL wrap_grant: ack=%b data=%h, required 0001/7f", ack, tx_data);
        end
        req = '0;
        wait_idle("wrap");
        n_cmp++;
        if (sent_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_sent: sent_cnt=%h, required 0000", sent_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_withdrawal();
        test_reset_mid();
        test_round_robin();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
